ula_multiciclo: RTL and testbench

- Parametrised, multi-cycle successor of the team's single-cycle ALU.
- Keeps the existing 4-bit opcode map and adds real iterative multiply and divide (opcodes 0010/0011), each producing a double-width result.
- Uses a start/busy/done handshake with a registered result.
- Sits in the execute stage of the multi-cycle datapath; the controller stalls on busy.

---
 rtl/ula_pkg.sv | 20 ++
 rtl/ula_mul_div_seq.sv | 78 +++++++
 rtl/ula_multiciclo.sv | 163 ++++++++++++++++
 tb/tb_ula_multiciclo.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/ula_pkg.sv
// ula_pkg: opcode map and FSM state encoding shared by the multi-cycle ALU.
package ula_pkg;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_MUL = 4'b0010;
  localparam logic [3:0] OP_DIV = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0100;
  localparam logic [3:0] OP_OR  = 4'b0101;
  localparam logic [3:0] OP_XOR = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_DONE
  } state_t;

endpackage

// File: rtl/ula_mul_div_seq.sv
// ula_mul_div_seq: iterative shift-add multiplier / restoring divider, one bit per cycle.
// done flags the final iteration; lo/hi then carry the finished values combinationally.
module ula_mul_div_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic             r_busy;
  logic             r_div;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_b;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_rsh;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_hi;
  logic [WIDTH-1:0] w_lo;
  logic             w_last;

  // r_hi is partial product / remainder, r_lo is multiplier / dividend->quotient
  always_comb begin
    w_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
    w_rsh  = {r_hi, r_lo[WIDTH-1]};
    w_diff = w_rsh - {1'b0, r_b};
    if (r_div) begin
      w_hi = w_diff[WIDTH] ? w_rsh[WIDTH-1:0] : w_diff[WIDTH-1:0];
      w_lo = {r_lo[WIDTH-2:0], ~w_diff[WIDTH]};
    end else begin
      w_hi = w_sum[WIDTH:1];
      w_lo = {w_sum[0], r_lo[WIDTH-1:1]};
    end
  end

  assign w_last = r_busy && (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_div  <= 1'b0;
      r_cnt  <= '0;
      r_hi   <= '0;
      r_lo   <= '0;
      r_b    <= '0;
    end else if (start) begin
      r_busy <= 1'b1;
      r_div  <= is_div;
      r_cnt  <= '0;
      r_hi   <= '0;
      r_lo   <= a;
      r_b    <= b;
    end else if (r_busy) begin
      r_hi  <= w_hi;
      r_lo  <= w_lo;
      r_cnt <= r_cnt + 1'b1;
      if (w_last) r_busy <= 1'b0;
    end
  end

  assign busy = r_busy;
  assign done = w_last;
  assign lo   = w_lo;
  assign hi   = w_hi;

endmodule

// File: rtl/ula_multiciclo.sv
// ula_multiciclo: multi-cycle ALU with start/busy/done handshake and registered result.
// Define ULA_SIGNED_EN for signed slt, mul and div.
module ula_multiciclo
  import ula_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int OP_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] In1,
  input  logic [WIDTH-1:0] In2,
  input  logic [OP_W-1:0]  OP,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             Zero_flag,
  output logic             div_by_zero
);

  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_result, r_res_hi;
  logic             r_zero, r_dbz;

  logic             w_acc, w_is_div, w_dbz, w_eng_start;
  logic             w_eng_busy, w_eng_done, w_lt;
  logic             w_load, w_ld_dbz;
  logic [WIDTH-1:0] w_alu, w_a, w_b;
  logic [WIDTH-1:0] w_eng_lo, w_eng_hi, w_fix_lo, w_fix_hi;
  logic [WIDTH-1:0] w_ld_lo, w_ld_hi;

  assign w_acc       = start && (r_state == S_IDLE);
  assign w_is_div    = (OP == OP_W'(OP_DIV));
  assign w_dbz       = w_is_div && (In2 == '0);
  assign w_eng_start = w_acc && !w_dbz &&
                       (w_is_div || OP == OP_W'(OP_MUL));

`ifdef ULA_SIGNED_EN
  logic                 w_sa, w_sb;
  logic                 r_neg_q, r_neg_r;
  logic [2*WIDTH-1:0]   w_prod;

  assign w_sa = In1[WIDTH-1];
  assign w_sb = In2[WIDTH-1];
  assign w_a  = w_sa ? -In1 : In1;
  assign w_b  = w_sb ? -In2 : In2;
  assign w_lt = $signed(In1) < $signed(In2);

  // remainder follows the dividend's sign
  always_ff @(posedge clk) begin
    if (rst) begin
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (w_eng_start) begin
      r_neg_q <= w_sa ^ w_sb;
      r_neg_r <= w_sa;
    end
  end

  always_comb begin
    w_prod   = {w_eng_hi, w_eng_lo};
    if (r_neg_q) w_prod = -w_prod;
    w_fix_lo = r_neg_q ? -w_eng_lo : w_eng_lo;
    w_fix_hi = r_neg_r ? -w_eng_hi : w_eng_hi;
    if (r_state == S_MUL) begin
      w_fix_lo = w_prod[WIDTH-1:0];
      w_fix_hi = w_prod[2*WIDTH-1:WIDTH];
    end
  end
`else
  assign w_a      = In1;
  assign w_b      = In2;
  assign w_lt     = In1 < In2;
  assign w_fix_lo = w_eng_lo;
  assign w_fix_hi = w_eng_hi;
`endif

  ula_mul_div_seq #(.WIDTH(WIDTH)) u_eng (
    .clk    (clk),
    .rst    (rst),
    .start  (w_eng_start),
    .is_div (w_is_div),
    .a      (w_a),
    .b      (w_b),
    .busy   (w_eng_busy),
    .done   (w_eng_done),
    .lo     (w_eng_lo),
    .hi     (w_eng_hi)
  );

  // OP_DIV only reaches here on divide by zero
  always_comb begin
    w_alu = '0;
    case (OP)
      OP_W'(OP_ADD): w_alu = In1 + In2;
      OP_W'(OP_SUB): w_alu = In1 - In2;
      OP_W'(OP_DIV): w_alu = '1;
      OP_W'(OP_AND): w_alu = In1 & In2;
      OP_W'(OP_OR):  w_alu = In1 | In2;
      OP_W'(OP_XOR): w_alu = In1 ^ In2;
      OP_W'(OP_SLT): w_alu = WIDTH'(w_lt);
      default:       w_alu = '0;
    endcase
  end

  always_comb begin
    w_next   = r_state;
    w_load   = 1'b0;
    w_ld_lo  = w_alu;
    w_ld_hi  = '0;
    w_ld_dbz = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_eng_start) begin
          w_next = w_is_div ? S_DIV : S_MUL;
        end else if (w_acc) begin
          w_next   = S_DONE;
          w_load   = 1'b1;
          w_ld_hi  = w_dbz ? In1 : '0;
          w_ld_dbz = w_dbz;
        end
      end
      S_MUL, S_DIV: begin
        if (w_eng_done) begin
          w_next  = S_DONE;
          w_load  = 1'b1;
          w_ld_lo = w_fix_lo;
          w_ld_hi = w_fix_hi;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_result <= '0;
      r_res_hi <= '0;
      r_zero   <= 1'b1;
      r_dbz    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_load) begin
        r_result <= w_ld_lo;
        r_res_hi <= w_ld_hi;
        r_zero   <= (w_ld_lo == '0);
        r_dbz    <= w_ld_dbz;
      end
    end
  end

  assign busy        = (r_state != S_IDLE) || w_eng_busy;
  assign done        = (r_state == S_DONE);
  assign result      = r_result;
  assign result_hi   = r_res_hi;
  assign Zero_flag   = r_zero;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_ula_multiciclo.sv
// tb_ula_multiciclo: scoreboard bench for the multi-cycle ALU (WIDTH=32).
module tb_ula_multiciclo;
  import ula_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [W-1:0] In1, In2;
  logic [3:0]   OP;
  logic         busy, done, Zero_flag, div_by_zero;
  logic [W-1:0] result, result_hi;

  typedef struct {
    string        name;
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic         dbz;
    int           due;
    int           lat;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int   bcnt  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  ula_multiciclo #(.WIDTH(W), .OP_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .In1         (In1),
    .In2         (In2),
    .OP          (OP),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .result_hi   (result_hi),
    .Zero_flag   (Zero_flag),
    .div_by_zero (div_by_zero)
  );

  task automatic chk(string nm, logic [W-1:0] act, logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // monitor: pops one expectation per done pulse
  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b1) begin
      bcnt = 0;
    end else begin
      if (busy === 1'b1) bcnt++;
      if (done === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", W'(1), W'(0));
        end else begin
          e = sb.pop_front();
          chk({e.name, "_result"}, result, e.res);
          chk({e.name, "_result_hi"}, result_hi, e.hi);
          chk({e.name, "_zero"}, W'(Zero_flag), W'(e.res == '0));
          chk({e.name, "_dbz"}, W'(div_by_zero), W'(e.dbz));
          chk({e.name, "_done_cycle"}, W'(cyc), W'(e.due));
          chk({e.name, "_busy_cycles"}, W'(bcnt), W'(e.lat + 1));
        end
        bcnt = 0;
      end
    end
  end

  task automatic issue(string nm, logic [3:0] op, logic [W-1:0] a,
                       logic [W-1:0] b, logic [W-1:0] er, logic [W-1:0] eh,
                       logic ed, int lat);
    exp_t e;
    @(negedge clk);
    OP = op; In1 = a; In2 = b; start = 1'b1;
    e.name = nm; e.res = er; e.hi = eh; e.dbz = ed;
    e.due = cyc + 1 + lat; e.lat = lat;
    sb.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
    In1 = $urandom; In2 = $urandom; OP = 4'($urandom);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      chk("done_timeout", W'(sb.size()), W'(0));
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic chk_reset(string nm);
    chk({nm, "_busy"}, W'(busy), W'(0));
    chk({nm, "_done"}, W'(done), W'(0));
    chk({nm, "_result"}, result, W'(0));
    chk({nm, "_result_hi"}, result_hi, W'(0));
    chk({nm, "_zero"}, W'(Zero_flag), W'(1));
    chk({nm, "_dbz"}, W'(div_by_zero), W'(0));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; In1 = '0; In2 = '0; OP = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_reset("reset");

    issue("add_5_7",   OP_ADD, 5, 7, 12, 0, 0, 0);            wait_idle();
    issue("sub_7_7",   OP_SUB, 7, 7, 0, 0, 0, 0);             wait_idle();
    issue("sub_3_5",   OP_SUB, 3, 5, 32'hFFFF_FFFE, 0, 0, 0); wait_idle();
    issue("add_wrap",  OP_ADD, 32'hFFFF_FFFF, 1, 0, 0, 0, 0); wait_idle();
    issue("and",       OP_AND, 32'hF0F0, 32'hFF00, 32'hF000, 0, 0, 0); wait_idle();
    issue("or",        OP_OR,  32'hF0F0, 32'h0F0F, 32'hFFFF, 0, 0, 0); wait_idle();
    issue("xor",       OP_XOR, 32'hFF, 32'h0F, 32'hF0, 0, 0, 0); wait_idle();
    issue("slt_3_9",   OP_SLT, 3, 9, 1, 0, 0, 0);             wait_idle();
    issue("slt_9_3",   OP_SLT, 9, 3, 0, 0, 0, 0);             wait_idle();
    issue("op_1000",   4'b1000, 32'h55, 32'h33, 0, 0, 0, 0);  wait_idle();
`ifdef ULA_SIGNED_EN
    issue("slt_m1_1",  OP_SLT, 32'hFFFF_FFFF, 1, 1, 0, 0, 0); wait_idle();
    issue("mul_m1_2",  OP_MUL, 32'hFFFF_FFFF, 2,
          32'hFFFF_FFFE, 32'hFFFF_FFFF, 0, W);                 wait_idle();
    issue("mul_m1_m1", OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
          1, 0, 0, W);                                         wait_idle();
    issue("div_m7_2",  OP_DIV, 32'hFFFF_FFF9, 2,
          32'hFFFF_FFFD, 32'hFFFF_FFFF, 0, W);                 wait_idle();
    issue("div_ovf",   OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
          32'h8000_0000, 0, 0, W);                             wait_idle();
`else
    issue("slt_m1_1",  OP_SLT, 32'hFFFF_FFFF, 1, 0, 0, 0, 0); wait_idle();
    issue("mul_ff_2",  OP_MUL, 32'hFFFF_FFFF, 2,
          32'hFFFF_FFFE, 1, 0, W);                             wait_idle();
    issue("mul_ff_ff", OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
          1, 32'hFFFF_FFFE, 0, W);                             wait_idle();
    issue("div_f9_2",  OP_DIV, 32'hFFFF_FFF9, 2,
          32'h7FFF_FFFC, 1, 0, W);                             wait_idle();
`endif
    issue("div_100_7", OP_DIV, 100, 7, 14, 2, 0, W);          wait_idle();
    issue("div_5_9",   OP_DIV, 5, 9, 0, 5, 0, W);             wait_idle();
    issue("mul_x_0",   OP_MUL, 12345, 0, 0, 0, 0, W);         wait_idle();
    issue("div_by_0",  OP_DIV, 100, 0, 32'hFFFF_FFFF, 100, 1, 0); wait_idle();
    issue("dbz_clear", OP_ADD, 1, 1, 2, 0, 0, 0);             wait_idle();

    // start during the done cycle must be ignored
    issue("add_hold",  OP_ADD, 20, 22, 42, 0, 0, 0);
    OP = OP_ADD; In1 = 100; In2 = 1; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);

    // start while the multiplier iterates must be ignored
    issue("mul_6_7",   OP_MUL, 6, 7, 42, 0, 0, W);
    repeat (4) @(negedge clk);
    OP = OP_ADD; In1 = 1; In2 = 1; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_idle();

    // reset mid-multiply aborts without a done pulse
    issue("mul_abort", OP_MUL, 6, 7, 42, 0, 0, W);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    sb.delete();
    @(posedge clk);
    #1 chk_reset("abort");
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk_reset("after_abort");

    issue("add_post",  OP_ADD, 2, 3, 5, 0, 0, 0);             wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
